mem_access_stage: RTL

Memory-access stage of the RISC-V core: sits directly downstream of the execute stage and consumes its ALU result, the forwarded rs2 value and the load/store controls. It turns each load/store into a single-word request on a variable-latency data-memory port with a ready/ack handshake. It performs byte-lane steering, write masking, load sign/zero extension and misalignment detection, and stalls the pipeline while a request is outstanding. Non-memory instructions pass through with one cycle of latency toward write-back.

---
 rtl/mem_access_stage.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
`timescale 1ns/1ps
// mem_access_stage: RISC-V memory-access stage.
// Each load or store becomes a single-word request on a variable-latency
// data-memory port. The stage steers byte lanes, builds the write mask,
// sign/zero-extends loads and flags misaligned accesses. It stalls the
// pipeline while a request is outstanding. Non-memory instructions reach
// write-back one cycle after they are accepted.
//
// Handshakes:
//   upstream   - an instruction is accepted on a rising edge where
//                in_valid & in_ready; in_ready is high only in IDLE.
//   data mem   - dmem_req rises the cycle after accept. dmem_req, dmem_addr,
//                dmem_we and dmem_wdata then hold until the first edge with
//                dmem_ack high, and dmem_rdata is sampled on that edge.
//                dmem_ack is ignored while no request is pending.
//   downstream - out_valid is a one-cycle pulse with no backpressure;
//                misaligned qualifies it.
module mem_access_stage #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] alu_out,
    input  logic [DWIDTH-1:0] store_data,
    input  logic              ctrl_mem_read,
    input  logic              ctrl_mem_write,
    input  logic [2:0]        ctrl_mem_func,
    input  logic              ctrl_reg_we,
    input  logic [4:0]        rd_addr,
    output logic              dmem_req,
    output logic [3:0]        dmem_we,
    output logic [AWIDTH-1:0] dmem_addr,
    output logic [DWIDTH-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DWIDTH-1:0] dmem_rdata,
    output logic              out_valid,
    output logic [DWIDTH-1:0] out_data,
    output logic [4:0]        out_rd,
    output logic              out_reg_we,
    output logic              misaligned,
    output logic              dbg_state
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t            state;
    logic [2:0]        func_q;
    logic [1:0]        lane_q;
    logic              store_q;
    logic [4:0]        rd_q;
    logic              reg_we_q;

    logic              mem_op;
    logic              is_byte;
    logic              is_half;
    logic              is_word;
    logic              addr_mis;
    logic [3:0]        req_we;
    logic [DWIDTH-1:0] req_wdata;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [DWIDTH-1:0] load_value;

    assign in_ready  = (state == IDLE);
    assign dbg_state = (state == BUSY);

    // Decode the access size, detect misalignment, and build the store mask and lane-replicated data.
    // BU/HU encodings exist only for loads, so a store carrying them falls back to a word access.
    always_comb begin
        mem_op    = ctrl_mem_read | ctrl_mem_write;
        is_byte   = 1'b0;
        is_half   = 1'b0;
        req_we    = 4'b0000;
        req_wdata = '0;
        case (ctrl_mem_func)
            3'b000:  is_byte = 1'b1;
            3'b001:  is_half = 1'b1;
            3'b100:  is_byte = !ctrl_mem_write;
            3'b101:  is_half = !ctrl_mem_write;
            default: ;
        endcase
        is_word  = !is_byte && !is_half;
        addr_mis = (is_half && alu_out[0]) || (is_word && (alu_out[1:0] != 2'b00));
        if (ctrl_mem_write) begin
            if (is_byte) begin
                req_we    = 4'b0001 << alu_out[1:0];
                req_wdata = {4{store_data[7:0]}};
            end else if (is_half) begin
                req_we    = 4'b0011 << {alu_out[1], 1'b0};
                req_wdata = {2{store_data[15:0]}};
            end else begin
                req_we    = 4'b1111;
                req_wdata = store_data;
            end
        end
    end

    // Extract the addressed lane from the returned word and extend it according to the registered funct3.
    always_comb begin
        rd_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
        rd_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (func_q)
            3'b000:  load_value = {{(DWIDTH-8){rd_byte[7]}}, rd_byte};
            3'b100:  load_value = {{(DWIDTH-8){1'b0}}, rd_byte};
            3'b001:  load_value = {{(DWIDTH-16){rd_half[15]}}, rd_half};
            3'b101:  load_value = {{(DWIDTH-16){1'b0}}, rd_half};
            default: load_value = dmem_rdata;
        endcase
    end

    // IDLE/BUSY controller with registered request and write-back outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 4'b0000;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_rd     <= 5'd0;
            out_reg_we <= 1'b0;
            misaligned <= 1'b0;
            func_q     <= 3'b000;
            lane_q     <= 2'b00;
            store_q    <= 1'b0;
            rd_q       <= 5'd0;
            reg_we_q   <= 1'b0;
        end else begin
            out_valid  <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (!mem_op) begin
                            out_valid  <= 1'b1;
                            out_data   <= alu_out;
                            out_rd     <= rd_addr;
                            out_reg_we <= ctrl_reg_we;
                        end else if (addr_mis) begin
                            // The faulting access never reaches memory and writes no register.
                            out_valid  <= 1'b1;
                            misaligned <= 1'b1;
                            out_data   <= '0;
                            out_rd     <= rd_addr;
                            out_reg_we <= 1'b0;
                        end else begin
                            dmem_req   <= 1'b1;
                            dmem_addr  <= {alu_out[AWIDTH-1:2], 2'b00};
                            dmem_we    <= req_we;
                            dmem_wdata <= req_wdata;
                            func_q     <= ctrl_mem_func;
                            lane_q     <= alu_out[1:0];
                            store_q    <= ctrl_mem_write;
                            rd_q       <= rd_addr;
                            reg_we_q   <= ctrl_reg_we;
                            state      <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (dmem_ack) begin
                        dmem_req   <= 1'b0;
                        out_valid  <= 1'b1;
                        out_rd     <= rd_q;
                        out_data   <= store_q ? '0 : load_value;
                        out_reg_we <= !store_q && reg_we_q;
                        state      <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
